// File: rtl/sevseg_capture_pkg.sv
// rtl/sevseg_capture_pkg.sv - shared constants and types for seven-segment capture
// Purpose: segment codes (active-low, bit6 = a ... bit0 = g), active-low anode
//          one-hot selects, capture FSM states and the binary result width.
// Ports:   none (package).
package sevseg_capture_pkg;

    localparam int NUM_W = 13;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

    localparam logic [3:0] AN_THOU  = 4'b0111;
    localparam logic [3:0] AN_HUND  = 4'b1011;
    localparam logic [3:0] AN_TENS  = 4'b1101;
    localparam logic [3:0] AN_ONES  = 4'b1110;
    localparam logic [3:0] AN_BLANK = 4'b1111;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/sevseg_capture_pattern_decode.sv
// rtl/sevseg_capture_pattern_decode.sv - seven-segment pattern to BCD digit decoder
// Purpose: purely combinational decode of one active-low segment pattern.
// Ports:   pattern [6:0] in  - active-low segments, bit6 = a ... bit0 = g
//          digit   [3:0] out - decoded value 0..9 (0 when not legal)
//          legal         out - high when pattern is one of the ten digit codes
module sevseg_pattern_decode
    import sevseg_capture_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       legal
);

    always_comb begin
        digit = 4'd0;
        legal = 1'b1;
        case (pattern)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevseg_capture.sv
// rtl/sevseg_capture.sv - four-digit multiplexed seven-segment receiver and BCD-to-binary converter
// Purpose: samples and deglitches anode/segment lines, rebuilds the BCD frame,
//          converts it to binary once all four digits have been seen.
// Ports:   clk, rst          - clock, synchronous active-high reset
//          Anode   [3:0] in  - active-low digit select, bit3 = thousands
//          LED_out [6:0] in  - active-low segments, bit6 = a
//          num    [12:0] out - last captured binary value
//          digits [15:0] out - last captured BCD frame, thousands in [15:12]
//          valid         out - one-cycle pulse when num/digits update
//          err           out - one-cycle pulse on a rejected pair or frame
module sevseg_capture
    import sevseg_capture_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = $clog2(STABLE_CYCLES) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       Anode,
    input  logic [6:0]       LED_out,
    output logic [NUM_W-1:0] num,
    output logic [15:0]      digits,
    output logic             valid,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [13:0]      ACC_MAX = 14'((1 << NUM_W) - 1);

    logic [3:0]       an_r, an_p;
    logic [6:0]       seg_r, seg_p;
    logic [CNT_W-1:0] cnt;
    logic             accepted;
    state_t           state, state_n;
    logic [3:0]       seen, seen_n;
    logic [15:0]      frame, frame_n;
    logic [13:0]      acc, acc_n, acc_sum;
    logic [1:0]       step, step_n;
    logic [NUM_W-1:0] num_n;
    logic [15:0]      digits_n;
    logic             valid_n, err_n;

    logic             same, accept;
    logic             an_legal;
    logic [1:0]       slot_idx;
    logic [3:0]       dec_digit;
    logic             dec_legal;

    sevseg_pattern_decode u_decode (
        .pattern (seg_r),
        .digit   (dec_digit),
        .legal   (dec_legal)
    );

    // A pair is taken once, on the cycle the counter first sits at its
    // saturation value; 'accepted' blocks repeats until the pair changes.
    assign same   = (an_r == an_p) && (seg_r == seg_p);
    assign accept = same && (cnt == CNT_MAX) && !accepted;

    always_comb begin
        an_legal = 1'b1;
        slot_idx = 2'd0;
        case (an_r)
            AN_THOU: slot_idx = 2'd3;
            AN_HUND: slot_idx = 2'd2;
            AN_TENS: slot_idx = 2'd1;
            AN_ONES: slot_idx = 2'd0;
            default: an_legal = 1'b0;
        endcase
    end

    // acc*10 + slot; step 0 picks thousands, step 3 picks ones.
    assign acc_sum = (acc << 3) + (acc << 1) + {10'd0, frame[{~step, 2'b00} +: 4]};

    always_comb begin
        state_n  = state;
        seen_n   = seen;
        frame_n  = frame;
        acc_n    = acc;
        step_n   = step;
        num_n    = num;
        digits_n = digits;
        valid_n  = 1'b0;
        err_n    = 1'b0;
        case (state)
            CAPTURE: begin
                if (accept && an_r != AN_BLANK) begin
                    if (!an_legal || !dec_legal) begin
                        err_n  = 1'b1;
                        seen_n = 4'b0000;
                    end else begin
                        frame_n[{slot_idx, 2'b00} +: 4] = dec_digit;
                        seen_n = seen | ~an_r;
                        if ((seen | ~an_r) == 4'b1111) begin
                            state_n = CONVERT;
                            acc_n   = 14'd0;
                            step_n  = 2'd0;
                        end
                    end
                end
            end
            CONVERT: begin
                acc_n  = acc_sum;
                step_n = step + 2'd1;
                // Result is registered on entry to DONE so it is visible there.
                if (step == 2'd3) begin
                    state_n = DONE;
                    if (acc_sum <= ACC_MAX) begin
                        valid_n  = 1'b1;
                        num_n    = acc_sum[NUM_W-1:0];
                        digits_n = frame;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            DONE: begin
                seen_n  = 4'b0000;
                state_n = CAPTURE;
            end
            default: state_n = CAPTURE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_r     <= AN_BLANK;
            an_p     <= AN_BLANK;
            seg_r    <= 7'h7f;
            seg_p    <= 7'h7f;
            cnt      <= '0;
            accepted <= 1'b0;
            state    <= CAPTURE;
            seen     <= 4'b0000;
            frame    <= 16'h0000;
            acc      <= 14'd0;
            step     <= 2'd0;
            num      <= '0;
            digits   <= 16'h0000;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            an_r  <= Anode;
            seg_r <= LED_out;
            an_p  <= an_r;
            seg_p <= seg_r;
            if (!same) begin
                cnt      <= '0;
                accepted <= 1'b0;
            end else begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
                if (accept) begin
                    accepted <= 1'b1;
                end
            end
            state  <= state_n;
            seen   <= seen_n;
            frame  <= frame_n;
            acc    <= acc_n;
            step   <= step_n;
            num    <= num_n;
            digits <= digits_n;
            valid  <= valid_n;
            err    <= err_n;
        end
    end

endmodule

// File: tb/tb_sevseg_capture.sv
// tb/tb_sevseg_capture.sv - self-checking bench for sevseg_capture
module tb_sevseg_capture;

    localparam int STABLE  = 16;
    localparam int VAL_LAT = STABLE + 6;
    localparam int ERR_LAT = STABLE + 2;
    localparam int HOLD    = 40;

    localparam logic [3:0] T_THOU = 4'b0111;
    localparam logic [3:0] T_HUND = 4'b1011;
    localparam logic [3:0] T_TENS = 4'b1101;
    localparam logic [3:0] T_ONES = 4'b1110;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  Anode;
    logic [6:0]  LED_out;
    logic [12:0] num;
    logic [15:0] digits;
    logic        valid;
    logic        err;

    sevseg_capture #(.STABLE_CYCLES(STABLE)) dut (
        .clk     (clk),
        .rst     (rst),
        .Anode   (Anode),
        .LED_out (LED_out),
        .num     (num),
        .digits  (digits),
        .valid   (valid),
        .err     (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_valid;
        int          at;
        logic [12:0] num;
        logic [15:0] digits;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [12:0] model_num    = 13'd0;
    logic [15:0] model_digits = 16'h0000;
    logic [6:0]  segtab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    logic [3:0]  antab  [4]  = '{T_ONES, T_TENS, T_HUND, T_THOU};

    function automatic int bcd2bin(input logic [15:0] d);
        return int'(d[15:12]) * 1000 + int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]);
    endfunction

    // Output monitor: every valid/err pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (valid === 1'b1 || err === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse cyc=%0d valid=%b err=%b num=%0d", cyc, valid, err, num);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_checks++;
                if ({valid, err} !== (e.is_valid ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL pulse_kind got valid/err=%b%b expected %b", valid, err,
                             e.is_valid ? 2'b10 : 2'b01);
                end
                n_checks++;
                if (cyc !== e.at) begin
                    n_fail++;
                    $display("FAIL pulse_cycle got %0d expected %0d", cyc, e.at);
                end
                n_checks++;
                if (num !== e.num) begin
                    n_fail++;
                    $display("FAIL num got %0d expected %0d", num, e.num);
                end
                n_checks++;
                if (digits !== e.digits) begin
                    n_fail++;
                    $display("FAIL digits got %h expected %h", digits, e.digits);
                end
            end
        end
    end

    // kind: 0 none, 1 valid frame, 2 rejected pair, 3 overflowed frame
    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n,
                        input int kind, input logic [15:0] bcd);
        int t;
        @(posedge clk);
        #1;
        Anode   = an;
        LED_out = seg;
        t = cyc;
        case (kind)
            1: begin
                model_num    = 13'(bcd2bin(bcd));
                model_digits = bcd;
                sb.push_back('{1'b1, t + VAL_LAT, model_num, model_digits});
            end
            2: sb.push_back('{1'b0, t + ERR_LAT, model_num, model_digits});
            3: sb.push_back('{1'b0, t + VAL_LAT, model_num, model_digits});
            default: ;
        endcase
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic send_frame(input logic [15:0] bcd);
        for (int i = 3; i >= 0; i--) begin
            hold(antab[i], segtab[bcd[i*4 +: 4]], HOLD,
                 (i == 0) ? ((bcd2bin(bcd) > 8191) ? 3 : 1) : 0, bcd);
        end
    endtask

    task automatic check_drained(input string name);
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL %s_pending got %0d outstanding expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        Anode = 4'hf;
        LED_out = 7'h7f;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) rst = 1'b0;
            n_checks++;
            if ({num, digits, valid, err} !== 31'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got num=%0d digits=%h valid=%b err=%b expected all 0",
                         cyc, num, digits, valid, err);
            end
            if (i < 2) begin
                Anode   = 4'($urandom);
                LED_out = 7'($urandom);
            end else begin
                Anode   = 4'hf;
                LED_out = 7'h7f;
            end
        end
        repeat (STABLE + 4) @(posedge clk);
        check_drained("reset");
    endtask

    task automatic test_clean_frame();
        send_frame(16'h1234);
        check_drained("clean_frame");
    endtask

    task automatic test_glitch();
        hold(T_THOU, segtab[1], HOLD, 0, 16'h0);
        hold(T_HUND, segtab[2], HOLD, 0, 16'h0);
        hold(T_TENS, segtab[3], HOLD, 0, 16'h0);
        hold(T_TENS, segtab[8], STABLE - 2, 0, 16'h0);
        hold(T_TENS, segtab[3], HOLD, 0, 16'h0);
        hold(T_ONES, segtab[4], HOLD, 1, 16'h1234);
        check_drained("glitch");
    endtask

    task automatic test_bad_pattern();
        hold(T_THOU, segtab[0], HOLD, 0, 16'h0);
        hold(T_HUND, segtab[0], HOLD, 0, 16'h0);
        hold(T_TENS, segtab[4], HOLD, 0, 16'h0);
        hold(T_HUND, 7'b1111110, HOLD, 2, 16'h0);
        hold(T_ONES, segtab[2], HOLD, 0, 16'h0);
        hold(T_THOU, segtab[0], HOLD, 0, 16'h0);
        hold(T_HUND, segtab[0], HOLD, 0, 16'h0);
        hold(T_TENS, segtab[4], HOLD, 1, 16'h0042);
        check_drained("bad_pattern");
    endtask

    task automatic test_overflow();
        send_frame(16'h9999);
        check_drained("overflow");
        n_checks++;
        if (num !== 13'd42) begin
            n_fail++;
            $display("FAIL overflow_retain got %0d expected 42", num);
        end
    endtask

    task automatic test_illegal_anode();
        hold(4'b0011, segtab[1], HOLD, 2, 16'h0);
        check_drained("illegal_anode");
    endtask

    task automatic test_reset_mid_convert();
        hold(T_THOU, segtab[5], HOLD, 0, 16'h0);
        hold(T_HUND, segtab[6], HOLD, 0, 16'h0);
        hold(T_TENS, segtab[7], HOLD, 0, 16'h0);
        @(posedge clk);
        #1;
        Anode   = T_ONES;
        LED_out = segtab[8];
        // Acceptance cycle A begins 17 edges after the drive; A+2 begins at edge 19.
        repeat (STABLE + 3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_num    = 13'd0;
        model_digits = 16'h0000;
        n_checks++;
        if ({num, digits, valid, err} !== 31'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs got num=%0d digits=%h valid=%b err=%b expected all 0",
                     num, digits, valid, err);
        end
        repeat (HOLD) @(posedge clk);
        check_drained("mid_reset");
        n_checks++;
        if (num !== 13'd0) begin
            n_fail++;
            $display("FAIL mid_reset_num got %0d expected 0", num);
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_glitch();
        test_bad_pattern();
        test_overflow();
        test_illegal_anode();
        test_reset_mid_convert();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
